delay_assign_sched: RTL and testbench

//  Schedules delayed register updates: captures a data value when a request is

---
 rtl/delay_assign_sched.sv | 152 +++++++++++++++
 tb/tb_delay_assign_sched.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/delay_assign_sched.sv
// Delayed-assignment scheduler: captures data on accept, writes it to out_data exactly max(N,1) edges later.
// Optional DLY_SCHED_CANCEL_EN adds a cancel input that drops every in-flight assignment.
module delay_assign_sched #(
    parameter int W     = 8,
    parameter int CW    = 4,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [W-1:0]               req_data,
    input  logic [CW-1:0]              req_count,
    output logic                       out_valid,
    output logic [W-1:0]               out_data,
    output logic                       collide,
    output logic [$clog2(DEPTH+1)-1:0] pending
`ifdef DLY_SCHED_CANCEL_EN
    ,
    input  logic                       cancel
`endif
);
    localparam int PW = $clog2(DEPTH+1);
    localparam int TW = CW + $clog2(DEPTH) + 1;

    logic [DEPTH-1:0] vld_q, vld_d;
    logic [CW-1:0]    cnt_q  [DEPTH];
    logic [CW-1:0]    cnt_d  [DEPTH];
    logic [W-1:0]     data_q [DEPTH];
    logic [W-1:0]     data_d [DEPTH];
    logic [TW-1:0]    tag_q  [DEPTH];
    logic [TW-1:0]    tag_d  [DEPTH];
    logic [TW-1:0]    tag_ctr_q, tag_ctr_d;
    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     out_data_q, out_data_d;
    logic             collide_q, collide_d;
    logic [PW-1:0]    pending_q, pending_d;

    logic             cancel_w;
    logic             accept;
    logic [DEPTH-1:0] done, alloc;
    logic             free_found, win_found, multi;
    logic [TW-1:0]    win_tag;
    logic [W-1:0]     win_data;

`ifdef DLY_SCHED_CANCEL_EN
    assign cancel_w = cancel;
`else
    assign cancel_w = 1'b0;
`endif

    // Modulo age compare: a is newer than b when a-b is nonzero and below half the tag range.
    function automatic logic newer(input logic [TW-1:0] a, input logic [TW-1:0] b);
        logic [TW-1:0] diff;
        diff = a - b;
        return (diff != '0) && !diff[TW-1];
    endfunction

    assign req_ready = (pending_q < PW'(DEPTH)) && !rst;
    assign accept    = req_valid && req_ready;

    always_comb begin
        done       = '0;
        alloc      = '0;
        free_found = 1'b0;
        win_found  = 1'b0;
        multi      = 1'b0;
        win_tag    = '0;
        win_data   = '0;
        vld_d      = vld_q;
        tag_ctr_d  = tag_ctr_q;
        pending_d  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt_d[i]  = cnt_q[i];
            data_d[i] = data_q[i];
            tag_d[i]  = tag_q[i];
            done[i]   = vld_q[i] && (cnt_q[i] == CW'(1)) && !cancel_w;
            if (!free_found && !vld_q[i]) begin
                alloc[i]   = 1'b1;
                free_found = 1'b1;
            end
        end

        for (int i = 0; i < DEPTH; i++) begin
            if (done[i]) begin
                if (win_found)
                    multi = 1'b1;
                if (!win_found || newer(tag_q[i], win_tag)) begin
                    win_tag  = tag_q[i];
                    win_data = data_q[i];
                end
                win_found = 1'b1;
            end
        end

        // A slot freed this edge is still busy now, so alloc never targets it.
        for (int i = 0; i < DEPTH; i++) begin
            if (cancel_w || done[i])
                vld_d[i] = 1'b0;
            else if (vld_q[i])
                cnt_d[i] = cnt_q[i] - CW'(1);
            if (accept && alloc[i]) begin
                vld_d[i]  = 1'b1;
                cnt_d[i]  = (req_count == '0) ? CW'(1) : req_count;
                data_d[i] = req_data;
                tag_d[i]  = tag_ctr_q;
            end
        end

        if (accept)
            tag_ctr_d = tag_ctr_q + TW'(1);
        for (int i = 0; i < DEPTH; i++)
            pending_d = pending_d + PW'(vld_d[i]);

        out_valid_d = win_found;
        out_data_d  = win_found ? win_data : out_data_q;
        collide_d   = multi;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q       <= '0;
            tag_ctr_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            collide_q   <= 1'b0;
            pending_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                cnt_q[i]  <= '0;
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else begin
            vld_q       <= vld_d;
            tag_ctr_q   <= tag_ctr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            collide_q   <= collide_d;
            pending_q   <= pending_d;
            for (int i = 0; i < DEPTH; i++) begin
                cnt_q[i]  <= cnt_d[i];
                data_q[i] <= data_d[i];
                tag_q[i]  <= tag_d[i];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign collide   = collide_q;
    assign pending   = pending_q;
endmodule

// File: tb/tb_delay_assign_sched.sv
// Directed bench for delay_assign_sched: per-edge vector table plus full/reset/cancel sequences.
module tb_delay_assign_sched;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [7:0] req_data = 8'h00;
    logic [3:0] req_count = 4'd0;
    logic       out_valid;
    logic [7:0] out_data;
    logic       collide;
    logic [2:0] pending;
    logic       cancel_r = 1'b0;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    delay_assign_sched #(.W(8), .CW(4), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_count (req_count),
        .out_valid (out_valid),
        .out_data  (out_data),
        .collide   (collide),
        .pending   (pending)
`ifdef DLY_SCHED_CANCEL_EN
        ,
        .cancel    (cancel_r)
`endif
    );

    typedef struct packed {
        logic       rst;
        logic       vld;
        logic [7:0] dat;
        logic [3:0] cnt;
        logic       ov;
        logic [7:0] od;
        logic       col;
        logic [2:0] pend;
        logic       rdy;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic v, input logic [7:0] d, input logic [3:0] c,
                                input logic eov, input logic [7:0] eod, input logic ecol,
                                input logic [2:0] epend, input logic erdy);
        vec_t t;
        t = '{rst: r, vld: v, dat: d, cnt: c, ov: eov, od: eod, col: ecol, pend: epend, rdy: erdy};
        return t;
    endfunction

    // Drive inputs for one edge, then check registered outputs just after it.
    task automatic step(input string nm, input logic r, input logic v, input logic [7:0] d,
                        input logic [3:0] c, input logic cx, input logic eov, input logic [7:0] eod,
                        input logic ecol, input logic [2:0] epend, input logic erdy);
        rst       = r;
        req_valid = v;
        req_data  = d;
        req_count = c;
        cancel_r  = cx;
        @(posedge clk);
        #1;
        tests++;
        if ({out_valid, out_data, collide, pending, req_ready} !== {eov, eod, ecol, epend, erdy}) begin
            failed++;
            $display("FAIL %s: got ov=%0b od=%h col=%0b pend=%0d rdy=%0b, expected ov=%0b od=%h col=%0b pend=%0d rdy=%0b",
                     nm, out_valid, out_data, collide, pending, req_ready, eov, eod, ecol, epend, erdy);
        end
        @(negedge clk);
    endtask

    vec_t tbl[24];

    initial begin
        // rst, vld, dat, cnt | ov, od, col, pend, rdy
        tbl[0]  = mk(1, 0, 8'h00, 0,  0, 8'h00, 0, 0, 0);
        tbl[1]  = mk(0, 1, 8'hA5, 3,  0, 8'h00, 0, 1, 1);
        tbl[2]  = mk(0, 0, 8'h00, 0,  0, 8'h00, 0, 1, 1);
        tbl[3]  = mk(0, 0, 8'h00, 0,  0, 8'h00, 0, 1, 1);
        tbl[4]  = mk(0, 0, 8'h00, 0,  1, 8'hA5, 0, 0, 1);
        tbl[5]  = mk(0, 0, 8'h00, 0,  0, 8'hA5, 0, 0, 1);
        tbl[6]  = mk(0, 1, 8'h11, 0,  0, 8'hA5, 0, 1, 1);
        tbl[7]  = mk(0, 1, 8'h22, 1,  1, 8'h11, 0, 1, 1);
        tbl[8]  = mk(0, 0, 8'h00, 0,  1, 8'h22, 0, 0, 1);
        tbl[9]  = mk(0, 0, 8'h00, 0,  0, 8'h22, 0, 0, 1);
        tbl[10] = mk(0, 1, 8'h01, 4,  0, 8'h22, 0, 1, 1);
        tbl[11] = mk(0, 0, 8'h00, 0,  0, 8'h22, 0, 1, 1);
        tbl[12] = mk(0, 1, 8'h02, 2,  0, 8'h22, 0, 2, 1);
        tbl[13] = mk(0, 0, 8'h00, 0,  0, 8'h22, 0, 2, 1);
        tbl[14] = mk(0, 0, 8'h00, 0,  1, 8'h02, 1, 0, 1);
        tbl[15] = mk(0, 0, 8'h00, 0,  0, 8'h02, 0, 0, 1);
        // Newer request lands in the lower slot; age, not index, must pick it.
        tbl[16] = mk(0, 1, 8'h33, 1,  0, 8'h02, 0, 1, 1);
        tbl[17] = mk(0, 1, 8'h44, 5,  1, 8'h33, 0, 1, 1);
        tbl[18] = mk(0, 1, 8'h55, 4,  0, 8'h33, 0, 2, 1);
        tbl[19] = mk(0, 0, 8'h00, 0,  0, 8'h33, 0, 2, 1);
        tbl[20] = mk(0, 0, 8'h00, 0,  0, 8'h33, 0, 2, 1);
        tbl[21] = mk(0, 0, 8'h00, 0,  0, 8'h33, 0, 2, 1);
        tbl[22] = mk(0, 0, 8'h00, 0,  1, 8'h55, 1, 0, 1);
        tbl[23] = mk(0, 0, 8'h00, 0,  0, 8'h55, 0, 0, 1);

        for (int i = 0; i < 24; i++)
            step($sformatf("vec%0d", i), tbl[i].rst, tbl[i].vld, tbl[i].dat, tbl[i].cnt, 1'b0,
                 tbl[i].ov, tbl[i].od, tbl[i].col, tbl[i].pend, tbl[i].rdy);

        // Fill all slots with the maximum delay; a held 5th request waits for a free slot.
        step("fill0", 0, 1, 8'h80, 15, 0,  0, 8'h55, 0, 1, 1);
        step("fill1", 0, 1, 8'h81, 15, 0,  0, 8'h55, 0, 2, 1);
        step("fill2", 0, 1, 8'h82, 15, 0,  0, 8'h55, 0, 3, 1);
        step("fill3", 0, 1, 8'h83, 15, 0,  0, 8'h55, 0, 4, 0);
        for (int i = 4; i < 15; i++)
            step($sformatf("full_hold%0d", i), 0, 1, 8'h99, 1, 0,  0, 8'h55, 0, 4, 0);
        step("full_first_done", 0, 1, 8'h99, 1, 0,  1, 8'h80, 0, 3, 1);
        step("full_accept5th",  0, 1, 8'h99, 1, 0,  1, 8'h81, 0, 3, 1);
        step("full_collide",    0, 0, 8'h00, 0, 0,  1, 8'h99, 1, 1, 1);
        step("full_last",       0, 0, 8'h00, 0, 0,  1, 8'h83, 0, 0, 1);

        // Reset with three assignments in flight discards them all.
        step("rmid0", 0, 1, 8'hC1, 10, 0,  0, 8'h83, 0, 1, 1);
        step("rmid1", 0, 1, 8'hC2, 10, 0,  0, 8'h83, 0, 2, 1);
        step("rmid2", 0, 1, 8'hC3, 10, 0,  0, 8'h83, 0, 3, 1);
        step("rmid3", 0, 0, 8'h00, 0,  0,  0, 8'h83, 0, 3, 1);
        step("rmid4", 0, 0, 8'h00, 0,  0,  0, 8'h83, 0, 3, 1);
        step("rmid_rst", 1, 1, 8'hEE, 1, 0,  0, 8'h00, 0, 0, 0);
        for (int i = 0; i < 12; i++)
            step($sformatf("rmid_after%0d", i), 0, 0, 8'h00, 0, 0,  0, 8'h00, 0, 0, 1);

`ifdef DLY_SCHED_CANCEL_EN
        step("cxl0", 0, 1, 8'hD1, 5, 0,  0, 8'h00, 0, 1, 1);
        step("cxl1", 0, 1, 8'hD2, 5, 0,  0, 8'h00, 0, 2, 1);
        step("cxl2", 0, 0, 8'h00, 0, 0,  0, 8'h00, 0, 2, 1);
        step("cxl3", 0, 1, 8'h7E, 2, 1,  0, 8'h00, 0, 1, 1);
        step("cxl4", 0, 0, 8'h00, 0, 0,  0, 8'h00, 0, 1, 1);
        step("cxl5", 0, 0, 8'h00, 0, 0,  1, 8'h7E, 0, 0, 1);
        step("cxl6", 0, 0, 8'h00, 0, 0,  0, 8'h7E, 0, 0, 1);
        step("cxl7", 0, 0, 8'h00, 0, 0,  0, 8'h7E, 0, 0, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
